seeed_tft_data_reader: RTL and testbench
========================================

Name: seeed_tft_data_reader

Overview:
- Reads pixel data back out of the Seeed TFT controller's frame memory over the 8080-style 8-bit parallel bus.
- It is the read-direction companion of the TFT data writer. It sits on the same physical bus and is muxed at top level; it owns the bus only while o_busy=1.
- Sequence: issue the memory-read command, discard the mandatory dummy read, then read R, G, B bytes per pixel.
- Each pixel is packed into a 32-bit word and pushed into the write side of an external ping-pong FIFO toward the host.

Parameters:
- DELAY_COUNT, 3: clocks each read/write strobe is held asserted (minimum 1).
- PIXEL_COUNT_WIDTH, 32: width of the pixel counter and i_num_pixels.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (asserted at 0).
- i_enable  input  1  block enable; a low level aborts any operation.
- i_start  input  1  one-cycle pulse; begins a frame read when idle.
- i_num_pixels  input  32  pixels to read; latched on i_start.
- i_mem_read_cmd  input  8  controller memory-read opcode (e.g. 0x2E); latched on i_start.
- o_busy  output  1  high from accepted i_start until return to IDLE.
- o_frame_done  output  1  one-cycle pulse when all pixels have been pushed.
- o_aborted  output  1  one-cycle pulse when i_enable falls while busy.
- i_fifo_rdy  input  2  ping-pong write-side ready flags.
- o_fifo_act  output  2  ping-pong write-side activate.
- o_fifo_stb  output  1  one-cycle write strobe.
- i_fifo_size  input  24  capacity of the activated buffer.
- o_fifo_data  output  32  pixel word {R,G,B,8'h00}.
- o_chip_select  output  1  bus chip select, active-high.
- o_cmd_mode  output  1  0 = command, 1 = data.
- o_data_out  output  8  bus write data.
- i_data_in  input  8  bus read data.
- o_write  output  1  write strobe, active-high.
- o_read  output  1  read strobe, active-high.
- o_data_out_en  output  1  1 = block drives the bus.

Behaviour:
- Reset values (rst=0, applied immediately, asynchronously): o_busy=0, o_frame_done=0, o_aborted=0, o_fifo_act=0, o_fifo_stb=0, o_fifo_data=0, o_chip_select=0, o_cmd_mode=1, o_data_out=0, o_write=0, o_read=0, o_data_out_en=1. State=IDLE; all counters 0.
- Reset mid-frame discards all progress; no done or abort pulse is produced.
- States: IDLE, CMD, TURN, DUMMY, RD_R, RD_G, RD_B, PUSH, FINISH.
- IDLE:
  - i_start with i_enable=1 latches inputs and sets o_busy.
  - If i_num_pixels==0: go to FINISH. No bus activity.
  - Otherwise: o_chip_select=1, o_cmd_mode=0, o_data_out_en=1, o_data_out=cmd, o_write=1, then go to CMD.
  - i_start while busy is ignored.
- CMD: o_write held for exactly DELAY_COUNT cycles. Then o_write=0, o_cmd_mode=1, o_data_out_en=0, go to TURN.
- TURN: one cycle with the bus released; no strobe asserted.
- Read bus cycle (used by DUMMY, RD_R, RD_G, RD_B):
  - o_read high for exactly DELAY_COUNT cycles.
  - i_data_in is sampled on the clk edge that ends the last high cycle.
  - o_read is then low for exactly 1 cycle before the next read.
- DUMMY: sampled byte is discarded.
- RD_R, RD_G, RD_B: store the sampled byte to bits [31:24], [23:16], [15:8] respectively; [7:0]=0. Go to PUSH after RD_B.
- FIFO acquire, evaluated every cycle while busy:
  - If o_fifo_act==0 and i_fifo_rdy!=0: set act[0] if rdy[0], else act[1]; clear the word counter.
  - Never assert both act bits.
- PUSH:
  - Waits (bus idle, CS held) until act!=0 and word count < i_fifo_size.
  - Then o_fifo_stb=1 for one cycle with o_fifo_data valid in the same cycle; word count +1; pixel count +1.
  - If the word count reaches i_fifo_size, deassert act on the next cycle.
  - If pixel count == latched i_num_pixels: deassert act (if a partial buffer is held), go to FINISH. Otherwise go to RD_R.
- FINISH: o_chip_select=0, o_data_out_en=1, o_frame_done pulse, o_busy=0, go to IDLE.
- Abort: i_enable=0 while busy:
  - Next cycle: all strobes 0, CS=0, act=0, o_aborted pulse, state IDLE.
  - Any partially assembled pixel is dropped.
- Counter wrap: the pixel counter does not exceed i_num_pixels. i_num_pixels=0xFFFFFFFF is legal and is not treated as a wrap.
- Per-pixel bus latency with no FIFO stall: 3*(DELAY_COUNT+1) read cycles plus 1 PUSH cycle.

Test Plan:
- DELAY_COUNT=2, i_num_pixels=1, cmd=0x2E, bus returns 0x11 (dummy), 0xA4, 0x58, 0xFC, FIFO always ready -> one write cycle of 0x2E with o_cmd_mode=0 lasting 2 clocks; 4 read strobes each 2 clocks high; single o_fifo_stb with data 0xA458FC00; o_frame_done pulse; CS=0.
- i_num_pixels=0 with i_start -> o_frame_done one cycle after IDLE exit; o_write and o_read never asserted.
- i_num_pixels=5, i_fifo_size=2, rdy alternating 2'b01 then 2'b10 -> strobes grouped 2, 2, 1 across act[0], act[1], act[0]; act released after each group; 5 words total in order.
- i_fifo_rdy=0 for 50 cycles after the first pixel is assembled -> PUSH stalls, CS remains 1, no read strobes; push completes within 2 cycles of rdy asserting.
- i_enable dropped during RD_G of pixel 3 of 10 -> o_aborted pulse, o_fifo_act=0, CS=0, exactly 2 words pushed, no o_frame_done.
- rst driven low mid-CMD without a clock edge -> outputs take reset values immediately; after release, a new i_start runs a full frame correctly.

Source files
------------

// File: rtl/seeed_tft_data_reader.sv
`default_nettype none
// ============================================================================
// Module   : seeed_tft_data_reader
// Purpose  : Reads pixel data back out of the Seeed TFT controller frame
//            memory over the 8080-style 8-bit bus. Issues the memory-read
//            opcode, discards the dummy read, then reads R, G, B per pixel
//            and pushes {R,G,B,8'h00} into a ping-pong FIFO write port.
// Ports    : clk/rst (async, active-low)  - clock and reset
//            i_enable/i_start/o_busy       - control, o_busy = bus owned
//            i_num_pixels/i_mem_read_cmd   - frame setup, latched on start
//            o_frame_done/o_aborted        - one-cycle completion pulses
//            i_fifo_rdy/o_fifo_act/o_fifo_stb/i_fifo_size/o_fifo_data
//                                          - ping-pong FIFO write side
//            o_chip_select/o_cmd_mode/o_data_out/i_data_in/o_write/o_read/
//            o_data_out_en                 - TFT parallel bus
// Revision : 1.0 - initial release
// ============================================================================
module seeed_tft_data_reader #(
  parameter int DELAY_COUNT       = 3,
  parameter int PIXEL_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic                         i_start,
  input  logic [PIXEL_COUNT_WIDTH-1:0] i_num_pixels,
  input  logic [7:0]                   i_mem_read_cmd,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_aborted,
  input  logic [1:0]                   i_fifo_rdy,
  output logic [1:0]                   o_fifo_act,
  output logic                         o_fifo_stb,
  input  logic [23:0]                  i_fifo_size,
  output logic [31:0]                  o_fifo_data,
  output logic                         o_chip_select,
  output logic                         o_cmd_mode,
  output logic [7:0]                   o_data_out,
  input  logic [7:0]                   i_data_in,
  output logic                         o_write,
  output logic                         o_read,
  output logic                         o_data_out_en
);

  localparam int c_DLY_W = (DELAY_COUNT > 1) ? $clog2(DELAY_COUNT) : 1;
  localparam logic [c_DLY_W-1:0] c_DLY_LAST = c_DLY_W'(DELAY_COUNT - 1);

  localparam logic [3:0] c_IDLE   = 4'd0;
  localparam logic [3:0] c_CMD    = 4'd1;
  localparam logic [3:0] c_TURN   = 4'd2;
  localparam logic [3:0] c_DUMMY  = 4'd3;
  localparam logic [3:0] c_RD_R   = 4'd4;
  localparam logic [3:0] c_RD_G   = 4'd5;
  localparam logic [3:0] c_RD_B   = 4'd6;
  localparam logic [3:0] c_PUSH   = 4'd7;
  localparam logic [3:0] c_FINISH = 4'd8;

  logic [3:0]                   state_q, state_d;
  logic [c_DLY_W-1:0]           dly_q, dly_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         abort_q, abort_d;
  logic [1:0]                   act_q, act_d;
  logic                         stb_q, stb_d;
  logic [31:0]                  fdata_q, fdata_d;
  logic                         cs_q, cs_d;
  logic                         cmd_mode_q, cmd_mode_d;
  logic [7:0]                   dout_q, dout_d;
  logic                         write_q, write_d;
  logic                         read_q, read_d;
  logic                         oe_q, oe_d;
  logic [PIXEL_COUNT_WIDTH-1:0] npix_q, npix_d;
  logic [PIXEL_COUNT_WIDTH-1:0] pix_q, pix_d;
  logic [23:0]                  wcnt_q, wcnt_d;
  logic [23:0]                  rgb_q, rgb_d;
  logic [PIXEL_COUNT_WIDTH-1:0] w_pix_inc;
  logic                         w_rd_last;

  assign w_pix_inc = pix_q + 1'b1;
  // Last high cycle of a read strobe: the byte is captured on its closing edge.
  assign w_rd_last = read_q && (dly_q == c_DLY_LAST);

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    act_d      = act_q;
    stb_d      = 1'b0;
    fdata_d    = fdata_q;
    cs_d       = cs_q;
    cmd_mode_d = cmd_mode_q;
    dout_d     = dout_q;
    write_d    = write_q;
    read_d     = read_q;
    oe_d       = oe_q;
    npix_d     = npix_q;
    pix_d      = pix_q;
    wcnt_d     = wcnt_q;
    rgb_d      = rgb_q;

    // Buffer management: release a full buffer one cycle after its last
    // strobe, grab a free buffer (preferring buffer 0) when none is held.
    if (busy_q) begin
      if (act_q != 2'b00) begin
        if (wcnt_q >= i_fifo_size) begin
          act_d = 2'b00;
        end
      end else if (i_fifo_rdy != 2'b00) begin
        act_d  = i_fifo_rdy[0] ? 2'b01 : 2'b10;
        wcnt_d = 24'd0;
      end
    end

    case (state_q)
      c_IDLE: begin
        if (i_start && i_enable) begin
          busy_d = 1'b1;
          npix_d = i_num_pixels;
          pix_d  = '0;
          if (i_num_pixels == '0) begin
            state_d = c_FINISH;
          end else begin
            cs_d       = 1'b1;
            cmd_mode_d = 1'b0;
            oe_d       = 1'b1;
            dout_d     = i_mem_read_cmd;
            write_d    = 1'b1;
            dly_d      = '0;
            state_d    = c_CMD;
          end
        end
      end
      c_CMD: begin
        if (dly_q == c_DLY_LAST) begin
          write_d    = 1'b0;
          cmd_mode_d = 1'b1;
          oe_d       = 1'b0;
          dly_d      = '0;
          state_d    = c_TURN;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      c_TURN: begin
        read_d  = 1'b1;
        dly_d   = '0;
        state_d = c_DUMMY;
      end
      c_DUMMY, c_RD_R, c_RD_G, c_RD_B: begin
        if (read_q) begin
          if (w_rd_last) begin
            read_d = 1'b0;
            dly_d  = '0;
            case (state_q)
              c_RD_R:  rgb_d[23:16] = i_data_in;
              c_RD_G:  rgb_d[15:8]  = i_data_in;
              c_RD_B:  rgb_d[7:0]   = i_data_in;
              default: rgb_d        = rgb_q;
            endcase
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end else begin
          // Single low cycle between strobes; RD_B hands over to PUSH.
          case (state_q)
            c_DUMMY: begin state_d = c_RD_R; read_d = 1'b1; end
            c_RD_R:  begin state_d = c_RD_G; read_d = 1'b1; end
            c_RD_G:  begin state_d = c_RD_B; read_d = 1'b1; end
            default: begin state_d = c_PUSH; end
          endcase
        end
      end
      c_PUSH: begin
        if ((act_q != 2'b00) && (wcnt_q < i_fifo_size)) begin
          stb_d   = 1'b1;
          fdata_d = {rgb_q, 8'h00};
          wcnt_d  = wcnt_q + 1'b1;
          pix_d   = w_pix_inc;
          if (w_pix_inc == npix_q) begin
            state_d = c_FINISH;
          end else begin
            read_d  = 1'b1;
            dly_d   = '0;
            state_d = c_RD_R;
          end
        end
      end
      c_FINISH: begin
        cs_d    = 1'b0;
        oe_d    = 1'b1;
        act_d   = 2'b00;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase

    // Enable loss wins over everything: drop the bus and any partial pixel.
    if (busy_q && !i_enable) begin
      state_d    = c_IDLE;
      busy_d     = 1'b0;
      abort_d    = 1'b1;
      done_d     = 1'b0;
      stb_d      = 1'b0;
      act_d      = 2'b00;
      cs_d       = 1'b0;
      write_d    = 1'b0;
      read_d     = 1'b0;
      cmd_mode_d = 1'b1;
      oe_d       = 1'b1;
      dly_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= c_IDLE;
      dly_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      act_q      <= 2'b00;
      stb_q      <= 1'b0;
      fdata_q    <= 32'd0;
      cs_q       <= 1'b0;
      cmd_mode_q <= 1'b1;
      dout_q     <= 8'd0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      oe_q       <= 1'b1;
      npix_q     <= '0;
      pix_q      <= '0;
      wcnt_q     <= 24'd0;
      rgb_q      <= 24'd0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      act_q      <= act_d;
      stb_q      <= stb_d;
      fdata_q    <= fdata_d;
      cs_q       <= cs_d;
      cmd_mode_q <= cmd_mode_d;
      dout_q     <= dout_d;
      write_q    <= write_d;
      read_q     <= read_d;
      oe_q       <= oe_d;
      npix_q     <= npix_d;
      pix_q      <= pix_d;
      wcnt_q     <= wcnt_d;
      rgb_q      <= rgb_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_frame_done  = done_q;
  assign o_aborted     = abort_q;
  assign o_fifo_act    = act_q;
  assign o_fifo_stb    = stb_q;
  assign o_fifo_data   = fdata_q;
  assign o_chip_select = cs_q;
  assign o_cmd_mode    = cmd_mode_q;
  assign o_data_out    = dout_q;
  assign o_write       = write_q;
  assign o_read        = read_q;
  assign o_data_out_en = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_seeed_tft_data_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seeed_tft_data_reader
// Purpose  : Self-checking bench for seeed_tft_data_reader. A bus responder
//            feeds random bytes; expected pixel words, buffer selection and
//            strobe timing are derived from the frame's byte list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seeed_tft_data_reader;

  localparam int DLY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic        i_start;
  logic [31:0] i_num_pixels;
  logic [7:0]  i_mem_read_cmd;
  logic        o_busy, o_frame_done, o_aborted;
  logic [1:0]  i_fifo_rdy;
  logic [1:0]  o_fifo_act;
  logic        o_fifo_stb;
  logic [23:0] i_fifo_size;
  logic [31:0] o_fifo_data;
  logic        o_chip_select, o_cmd_mode;
  logic [7:0]  o_data_out;
  logic [7:0]  i_data_in;
  logic        o_write, o_read, o_data_out_en;

  always #5 clk = ~clk;

  seeed_tft_data_reader #(.DELAY_COUNT(DLY), .PIXEL_COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_start(i_start),
    .i_num_pixels(i_num_pixels), .i_mem_read_cmd(i_mem_read_cmd),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_aborted(o_aborted),
    .i_fifo_rdy(i_fifo_rdy), .o_fifo_act(o_fifo_act), .o_fifo_stb(o_fifo_stb),
    .i_fifo_size(i_fifo_size), .o_fifo_data(o_fifo_data),
    .o_chip_select(o_chip_select), .o_cmd_mode(o_cmd_mode),
    .o_data_out(o_data_out), .i_data_in(i_data_in), .o_write(o_write),
    .o_read(o_read), .o_data_out_en(o_data_out_en)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference data for the current frame (written by the stimulus only).
  logic [7:0]  bus_bytes [64];
  logic [31:0] exp_words [32];
  logic [7:0]  exp_cmd;
  int          exp_fsz;
  bit          alt_mode;
  bit          no_stall;
  logic [1:0]  rdy_fixed;

  // Monitor-owned state.
  int   rd_cnt, wr_cnt, stb_cnt, done_cnt, abort_cnt;
  int   rd_len, wr_len, gap, since_stb;
  bit   prev_rd, prev_wr;
  logic [1:0] prev_act;
  bit   buf_sel;

  assign i_fifo_rdy = alt_mode ? (buf_sel ? 2'b10 : 2'b01) : rdy_fixed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Word k lands in buffer k/size; buffers alternate 0,1,0.. in alternate mode.
  function automatic logic [1:0] exp_act(input int k);
    if (!alt_mode) return 2'b01;
    return (((k / exp_fsz) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      prev_rd = 0; prev_wr = 0; rd_len = 0; wr_len = 0; gap = 0;
      prev_act = 2'b00;
    end else begin
      if (i_start && !o_busy) begin
        rd_cnt = 0; wr_cnt = 0; stb_cnt = 0; done_cnt = 0; abort_cnt = 0;
        buf_sel = 0; since_stb = 0;
      end
      if (o_read) begin
        if (!prev_rd) begin
          if (rd_cnt > 0 && ((rd_cnt % 3) != 1 || rd_cnt == 1))
            chk("read_gap", 64'(gap), 64'd1);
          i_data_in = bus_bytes[rd_cnt];
          rd_cnt++;
          rd_len = 0;
        end
        rd_len++;
      end else begin
        if (prev_rd) begin
          if (!o_aborted) chk("read_len", 64'(rd_len), 64'(DLY));
          gap = 0;
        end
        gap++;
      end
      if (o_write) begin
        if (!prev_wr) begin
          chk("write_cmd", {o_data_out, o_cmd_mode, o_data_out_en, o_chip_select},
              {exp_cmd, 1'b0, 1'b1, 1'b1});
          wr_cnt++;
          wr_len = 0;
        end
        wr_len++;
      end else if (prev_wr) begin
        chk("write_len", 64'(wr_len), 64'(DLY));
      end
      since_stb++;
      if (o_fifo_stb) begin
        chk("stb_data", o_fifo_data, exp_words[stb_cnt]);
        chk("stb_act", o_fifo_act, exp_act(stb_cnt));
        if (no_stall && stb_cnt > 0)
          chk("pix_latency", 64'(since_stb), 64'(3 * (DLY + 1) + 1));
        since_stb = 0;
        stb_cnt++;
      end
      if (prev_act != 2'b00 && o_fifo_act == 2'b00) buf_sel = ~buf_sel;
      if (o_frame_done) done_cnt++;
      if (o_aborted) abort_cnt++;
      prev_rd  = o_read;
      prev_wr  = o_write;
      prev_act = o_fifo_act;
    end
  end

  task automatic prep(input int n);
    for (int i = 0; i < 1 + 3 * n; i++) bus_bytes[i] = 8'($urandom);
    for (int p = 0; p < n; p++)
      exp_words[p] = {bus_bytes[1 + 3*p], bus_bytes[2 + 3*p], bus_bytes[3 + 3*p], 8'h00};
  endtask

  task automatic start_frame(input logic [31:0] n, input logic [7:0] cmd);
    @(posedge clk); #1;
    i_num_pixels = n; i_mem_read_cmd = cmd; exp_cmd = cmd; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    bit got;
    got = 0; cyc = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (o_frame_done) got = 1;
    end
    chk("frame_done_seen", 64'(got), 64'd1);
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_busy"}, o_busy, 1'b0);
    chk({pfx, "_done"}, o_frame_done, 1'b0);
    chk({pfx, "_aborted"}, o_aborted, 1'b0);
    chk({pfx, "_act"}, o_fifo_act, 2'b00);
    chk({pfx, "_stb"}, o_fifo_stb, 1'b0);
    chk({pfx, "_fdata"}, o_fifo_data, 32'd0);
    chk({pfx, "_cs"}, o_chip_select, 1'b0);
    chk({pfx, "_cmd_mode"}, o_cmd_mode, 1'b1);
    chk({pfx, "_dout"}, o_data_out, 8'd0);
    chk({pfx, "_write"}, o_write, 1'b0);
    chk({pfx, "_read"}, o_read, 1'b0);
    chk({pfx, "_oe"}, o_data_out_en, 1'b1);
  endtask

  initial begin
    int  cyc;
    int  lat;
    bit  ok;
    rst = 1'b0; i_enable = 1'b1; i_start = 1'b0; i_num_pixels = 0;
    i_mem_read_cmd = 8'h2E; exp_cmd = 8'h2E; i_fifo_size = 24'd16; exp_fsz = 16;
    alt_mode = 0; no_stall = 1; rdy_fixed = 2'b01;
    for (int i = 0; i < 64; i++) bus_bytes[i] = 8'h00;
    for (int i = 0; i < 32; i++) exp_words[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1 rst = 1'b1;

    // Directed single pixel with fixed bus bytes; a second start mid-frame is ignored.
    bus_bytes[0] = 8'h11; bus_bytes[1] = 8'hA4; bus_bytes[2] = 8'h58; bus_bytes[3] = 8'hFC;
    exp_words[0] = 32'hA458FC00;
    start_frame(32'd1, 8'h2E);
    repeat (4) @(posedge clk);
    #1 i_num_pixels = 32'd7; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done(2000, cyc);
    chk("p1_words", 64'(stb_cnt), 64'd1);
    chk("p1_reads", 64'(rd_cnt), 64'd4);
    chk("p1_writes", 64'(wr_cnt), 64'd1);
    chk("p1_cs_off", o_chip_select, 1'b0);
    chk("p1_busy_off", o_busy, 1'b0);
    chk("p1_act_off", o_fifo_act, 2'b00);
    chk("p1_data_held", o_fifo_data, 32'hA458FC00);

    // Zero pixels: no bus traffic, done one cycle after leaving IDLE.
    start_frame(32'd0, 8'h5A);
    wait_done(20, cyc);
    chk("p0_latency", 64'(cyc), 64'd2);
    chk("p0_reads", 64'(rd_cnt), 64'd0);
    chk("p0_writes", 64'(wr_cnt), 64'd0);
    chk("p0_words", 64'(stb_cnt), 64'd0);

    // Five pixels into alternating buffers of two words.
    prep(5);
    i_fifo_size = 24'd2; exp_fsz = 2; alt_mode = 1;
    start_frame(32'd5, 8'($urandom));
    wait_done(2000, cyc);
    chk("pp_words", 64'(stb_cnt), 64'd5);
    chk("pp_reads", 64'(rd_cnt), 64'd16);
    chk("pp_act_off", o_fifo_act, 2'b00);
    alt_mode = 0; i_fifo_size = 24'd16; exp_fsz = 16;

    // FIFO not ready: PUSH must stall with CS held and the bus quiet.
    prep(2);
    no_stall = 0; rdy_fixed = 2'b00;
    start_frame(32'd2, 8'($urandom));
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (rd_cnt == 4 && !o_read) ok = 1;
    end
    chk("stall_reached", 64'(ok), 64'd1);
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(o_chip_select && !o_read && !o_fifo_stb && o_busy)) ok = 0;
    end
    chk("stall_hold", 64'(ok), 64'd1);
    chk("stall_no_reads", 64'(rd_cnt), 64'd4);
    @(posedge clk); #1 rdy_fixed = 2'b01;
    lat = 0; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      lat++;
      if (o_fifo_stb) ok = 1;
    end
    chk("stall_release", 64'(ok && lat <= 2), 64'd1);
    wait_done(2000, cyc);
    chk("stall_words", 64'(stb_cnt), 64'd2);
    no_stall = 1;

    // Start while disabled is ignored.
    i_enable = 1'b0;
    start_frame(32'd3, 8'h2E);
    @(negedge clk);
    chk("dis_start_busy", o_busy, 1'b0);
    @(posedge clk); #1 i_enable = 1'b1;

    // Abort during RD_G of pixel 3 of 10.
    prep(10);
    start_frame(32'd10, 8'($urandom));
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (rd_cnt == 9) ok = 1;
    end
    chk("abort_reached", 64'(ok), 64'd1);
    @(posedge clk); #1 i_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_pulse", o_aborted, 1'b1);
    chk("abort_act", o_fifo_act, 2'b00);
    chk("abort_cs", o_chip_select, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_read", o_read, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_words", 64'(stb_cnt), 64'd2);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_once", 64'(abort_cnt), 64'd1);
    @(posedge clk); #1 i_enable = 1'b1;

    // Asynchronous reset in the middle of the command write.
    prep(3);
    start_frame(32'd3, 8'($urandom));
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (o_write) ok = 1;
    end
    chk("cmd_reached", 64'(ok), 64'd1);
    #2 rst = 1'b0;
    #1 check_reset("arst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    prep(3);
    start_frame(32'd3, 8'($urandom));
    wait_done(2000, cyc);
    chk("post_rst_words", 64'(stb_cnt), 64'd3);
    chk("post_rst_reads", 64'(rd_cnt), 64'd10);
    chk("post_rst_writes", 64'(wr_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
